// File: rtl/cache_port_arbiter_pkg.sv
// Shared encodings for the two-port cache arbiter and the cache controller it feeds.
// Command and FSM encodings live here so both sides agree on the wire values.
package cache_port_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    CTRL_CLR = 2'b00,
    CTRL_NOP = 2'b01,
    CTRL_RD  = 2'b10,
    CTRL_WR  = 2'b11
  } ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CLRWAIT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // A no-op command is never worth arbitrating for.
  function automatic logic eligible(input logic req, input logic [1:0] ctrl);
    return req && (ctrl != CTRL_NOP);
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundle of requester-side and cache-controller-side signals of the arbiter.
// slave = arbiter view, master = requesters plus cache controller.
interface cache_port_arbiter_if #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8
);
  logic                req0, req1;
  logic [1:0]          ctrl0, ctrl1;
  logic                ind0, ind1;
  logic [addrSize-1:0] addr0, addr1;
  logic [ramWidth-1:0] wdata0, wdata1;
  logic                gnt0, gnt1;
  logic                done0, done1;
  logic [ramWidth-1:0] rdata0, rdata1;
  logic                err;
  logic [1:0]          cc_ctrl;
  logic                cc_indirect;
  logic [addrSize-1:0] cc_addr;
  logic [ramWidth-1:0] cc_dataIn;
  logic                cc_outputReady;
  logic [ramWidth-1:0] cc_dataOut;

  modport slave (
    input  req0, req1, ctrl0, ctrl1, ind0, ind1, addr0, addr1, wdata0, wdata1,
    input  cc_outputReady, cc_dataOut,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err,
    output cc_ctrl, cc_indirect, cc_addr, cc_dataIn
  );

  modport master (
    output req0, req1, ctrl0, ctrl1, ind0, ind1, addr0, addr1, wdata0, wdata1,
    output cc_outputReady, cc_dataOut,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err,
    input  cc_ctrl, cc_indirect, cc_addr, cc_dataIn
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the port granted last loses a tie.
// A lone requester always wins; with no request the output is meaningless.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);
  always_comb begin
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end
endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache controller between fetch (port 0) and data (port 1).
// One command in flight at a time; completion or timeout returns a done pulse to the owner.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int ramWidth = 8,
  parameter int addrSize = 8,
  parameter int TIMEOUT  = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_port_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e state, state_nxt;

  logic [NUM_PORTS-1:0]               req_v, elig, ind_v;
  logic [NUM_PORTS-1:0][1:0]          ctrl_v;
  logic [NUM_PORTS-1:0][addrSize-1:0] addr_v;
  logic [NUM_PORTS-1:0][ramWidth-1:0] wdata_v;
  logic [NUM_PORTS-1:0][ramWidth-1:0] rdata_q;

  logic                winner, last, owner, grant;
  ctrl_e               cmd_ctrl;
  logic                cmd_ind;
  logic [addrSize-1:0] cmd_addr;
  logic [ramWidth-1:0] cmd_wdata;
  logic [CW-1:0]       cnt;
  logic                err_q;
  logic                ready_hit, timeout_hit;

  assign req_v   = {bus.req1,   bus.req0};
  assign ctrl_v  = {bus.ctrl1,  bus.ctrl0};
  assign ind_v   = {bus.ind1,   bus.ind0};
  assign addr_v  = {bus.addr1,  bus.addr0};
  assign wdata_v = {bus.wdata1, bus.wdata0};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_elig
    assign elig[p] = eligible(req_v[p], ctrl_v[p]);
  end

  rr_arb2 u_rr (
    .req    (elig),
    .last   (last),
    .winner (winner)
  );

  // Grant is combinational in IDLE; gated by rst_n so it is quiet during reset.
  assign grant       = rst_n && (state == S_IDLE) && (|elig);
  assign ready_hit   = (state == S_WAIT) && bus.cc_outputReady;
  // A strobe arriving on the last allowed cycle wins over the timeout.
  assign timeout_hit = (state == S_WAIT) && !bus.cc_outputReady && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (|elig) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = (cmd_ctrl == CTRL_CLR) ? S_CLRWAIT : S_WAIT;
      S_WAIT:    if (ready_hit || timeout_hit) state_nxt = S_DONE;
      S_CLRWAIT: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Command registers; last starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      cmd_ctrl  <= CTRL_NOP;
      cmd_ind   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant) begin
      last      <= winner;
      owner     <= winner;
      cmd_ctrl  <= ctrl_e'(ctrl_v[winner]);
      cmd_ind   <= ind_v[winner];
      cmd_addr  <= addr_v[winner];
      cmd_wdata <= wdata_v[winner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state == S_ISSUE)  cnt <= '0;
    else if (state == S_WAIT)   cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (timeout_hit) err_q <= 1'b1;
      if (ready_hit && cmd_ctrl == CTRL_RD) rdata_q[owner] <= bus.cc_dataOut;
    end
  end

  always_comb begin
    bus.cc_ctrl = CTRL_NOP;
    if (state == S_ISSUE || state == S_WAIT) bus.cc_ctrl = cmd_ctrl;
  end

  assign bus.cc_indirect = cmd_ind;
  assign bus.cc_addr     = cmd_addr;
  assign bus.cc_dataIn   = cmd_wdata;

  assign bus.gnt0   = grant && !winner;
  assign bus.gnt1   = grant &&  winner;
  assign bus.done0  = (state == S_DONE) && !owner;
  assign bus.done1  = (state == S_DONE) &&  owner;
  assign bus.rdata0 = rdata_q[0];
  assign bus.rdata1 = rdata_q[1];
  assign bus.err    = err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed plus randomized bench for cache_port_arbiter with TIMEOUT=8.
// Expected grant order, latency, rdata and err come from a small behavioural model.
module tb_cache_port_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.ramWidth(8), .addrSize(8)) bus ();

  cache_port_arbiter #(.ramWidth(8), .addrSize(8), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int prio;                // port that wins a tie
  logic [7:0] exp_rdata [2];
  logic exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prio = 0; exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   32'({bus.gnt1, bus.gnt0}), 32'd0);
    chk({tag, "_done"},  32'({bus.done1, bus.done0}), 32'd0);
    chk({tag, "_err"},   32'(bus.err), 32'd0);
    chk({tag, "_rdata"}, 32'({bus.rdata1, bus.rdata0}), 32'd0);
    chk({tag, "_ccctl"}, 32'(bus.cc_ctrl), 32'd1);
    chk({tag, "_ccbus"}, 32'({bus.cc_indirect, bus.cc_addr, bus.cc_dataIn}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One arbitrated operation. k = WAIT cycle on which cc_outputReady rises (0 = never).
  task automatic run_op(input logic [1:0] rq, input logic [1:0] c0, input logic [1:0] c1,
                        input logic i0, input logic i1, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] w0, input logic [7:0] w1, input int k,
                        input logic [7:0] rd, input logic spur, input logic hold);
    logic [1:0] el, ec;
    logic ei;
    logic [7:0] ea, ew;
    int p, lat, nctrl, wc, exp_lat, exp_n;
    bit seen, xg, fin;
    el[0] = rq[0] && (c0 != 2'b01);
    el[1] = rq[1] && (c1 != 2'b01);
    p  = (el == 2'b11) ? prio : (el[1] ? 1 : 0);
    ec = p ? c1 : c0; ei = p ? i1 : i0; ea = p ? a1 : a0; ew = p ? w1 : w0;
    fin = (k >= 1 && k <= TO);
    wc  = fin ? k : TO;
    bus.req0 = rq[0]; bus.req1 = rq[1]; bus.ctrl0 = c0; bus.ctrl1 = c1;
    bus.ind0 = i0; bus.ind1 = i1; bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = w0; bus.wdata1 = w1;
    #1;
    chk("gnt", 32'({bus.gnt1, bus.gnt0}), p ? 32'd2 : 32'd1);
    prio = 1 - p;
    lat = 0; nctrl = 0; seen = 0; xg = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (!hold) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      if (bus.gnt0 || bus.gnt1) xg = 1;
      if (bus.cc_ctrl == ec) nctrl++;
      if (i == 1) chk("issue_cmd", 32'({bus.cc_indirect, bus.cc_addr, bus.cc_dataIn}), 32'({ei, ea, ew}));
      if (bus.done0 || bus.done1) begin
        seen = 1; lat = i;
        chk("done_port", 32'({bus.done1, bus.done0}), p ? 32'd2 : 32'd1);
        chk("done_cmdregs", 32'({bus.cc_ctrl, bus.cc_indirect, bus.cc_addr, bus.cc_dataIn}),
            32'({2'b01, ei, ea, ew}));
      end
      bus.cc_outputReady = 1'b0;
      if (spur && i == 1) begin bus.cc_outputReady = 1'b1; bus.cc_dataOut = ~rd; end
      if (k > 0 && i == 1 + k && !seen) begin bus.cc_outputReady = 1'b1; bus.cc_dataOut = rd; end
    end
    bus.cc_outputReady = 1'b0;
    if (ec == 2'b00) begin exp_lat = 3; exp_n = 1; end
    else begin
      exp_lat = 2 + wc; exp_n = 1 + wc;
      if (!fin) exp_err = 1'b1;
      else if (ec == 2'b10) exp_rdata[p] = rd;
    end
    if (!seen) chk("done_seen", 32'd0, 32'd1);
    else begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("cmd_cycles", 32'(nctrl), 32'(exp_n));
      chk("rdata0", 32'(bus.rdata0), 32'(exp_rdata[0]));
      chk("rdata1", 32'(bus.rdata1), 32'(exp_rdata[1]));
      chk("err", 32'(bus.err), 32'(exp_err));
    end
    chk("no_extra_gnt", 32'(xg), 32'd0);
    @(negedge clk);
  endtask

  logic [1:0] rq, c0, c1;
  int m0, m1;

  function automatic logic [1:0] mode_ctrl(input int m);
    case (m)
      1: return 2'b01;
      2: return 2'b00;
      3: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b0; bus.ctrl0 = 2'b10; bus.ctrl1 = 2'b01;
    bus.ind0 = 1'b0; bus.ind1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0; bus.cc_outputReady = 1'b0; bus.cc_dataOut = '0;
    #1;
    chk_reset_outputs("reset");          // eligible request held during reset: still no grant
    @(negedge clk); bus.req0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Port 0 read, strobe on the 4th WAIT cycle.
    run_op(2'b01, 2'b10, 2'b01, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, 4, 8'hA5, 1'b0, 1'b0);

    // No-op is filtered out.
    bus.req0 = 1'b1; bus.ctrl0 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nop_gnt", 32'(bus.gnt0), 32'd0);
      chk("nop_ccctl", 32'(bus.cc_ctrl), 32'd1);
      @(negedge clk);
    end
    bus.req0 = 1'b0;

    // Both ports held from reset: order 0, 1, 0.
    do_reset();
    run_op(2'b11, 2'b10, 2'b10, 1'b1, 1'b0, 8'h11, 8'h22, 8'h00, 8'h00, 2, 8'h5A, 1'b0, 1'b1);
    run_op(2'b11, 2'b10, 2'b10, 1'b1, 1'b0, 8'h11, 8'h22, 8'h00, 8'h00, 3, 8'hC3, 1'b0, 1'b1);
    run_op(2'b11, 2'b10, 2'b10, 1'b1, 1'b0, 8'h11, 8'h22, 8'h00, 8'h00, 1, 8'h7E, 1'b0, 1'b0);

    // Clear on port 1 (strobe lands in CLRWAIT and must be ignored), then a write.
    run_op(2'b10, 2'b01, 2'b00, 1'b0, 1'b1, 8'h00, 8'h44, 8'h00, 8'h99, 1, 8'hEE, 1'b1, 1'b0);
    run_op(2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 8'h00, 8'h45, 8'h00, 8'h67, 2, 8'hDD, 1'b0, 1'b0);

    // Strobe on the same cycle the timeout would fire: completion, no err.
    run_op(2'b01, 2'b10, 2'b01, 1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 8'h00, TO, 8'h3D, 1'b1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do begin
        m0 = $urandom_range(0, 4); m1 = $urandom_range(0, 4);
      end while (m0 < 2 && m1 < 2);
      rq = {1'(m1 != 0), 1'(m0 != 0)};
      c0 = mode_ctrl(m0); c1 = mode_ctrl(m1);
      run_op(rq, c0, c1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), $urandom_range(1, TO - 1), 8'($urandom),
             1'($urandom), 1'b0);
    end

    // Timeout, then err must stay set across a normal operation.
    run_op(2'b01, 2'b10, 2'b01, 1'b0, 1'b0, 8'h90, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    run_op(2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 8'h00, 8'h91, 8'h00, 8'h00, 3, 8'h4B, 1'b0, 1'b0);

    // Reset while in WAIT.
    bus.req0 = 1'b1; bus.ctrl0 = 2'b10; bus.addr0 = 8'h77;
    @(negedge clk); bus.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midwait");
    @(negedge clk); rst_n = 1'b1; model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'({bus.done1, bus.done0}), 32'd0);
      chk("post_rst_ccctl", 32'(bus.cc_ctrl), 32'd1);
    end
    run_op(2'b11, 2'b10, 2'b11, 1'b0, 1'b1, 8'h12, 8'h34, 8'h00, 8'h56, 2, 8'h69, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
